// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack I/O peripheral: register offsets within the
// 8-word window and a ceil(log2) helper used to size counters.
package hack_io_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PWM_W  = 8;

  localparam logic [2:0] OFF_IN_STATE = 3'd0;
  localparam logic [2:0] OFF_IN_EDGE  = 3'd1;
  localparam logic [2:0] OFF_LED      = 3'd2;
  localparam logic [2:0] OFF_TIMER    = 3'd3;
  localparam logic [2:0] OFF_CMP      = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;
  localparam logic [2:0] OFF_PWM      = 3'd6;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

  // Width of a counter holding 0..n-1, at least one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-flop synchroniser followed by a stability counter.
// The accepted level only follows the synchronised input once it has differed
// from the current level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   raw_i        raw asynchronous input
//   state_o      debounced level (registered)
//   rise_c_o     combinational: high in the cycle whose edge moves state 0->1
module io_debounce
  import hack_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic        INIT            = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic state_o,
  output logic rise_c_o
);

  localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where synced matches state restarts the count, rejecting glitches
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) state_d = sync2_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o  = state_q;
  assign rise_c_o = state_d & ~state_q;

endmodule

// File: rtl/hack_io_ctrl.sv
// Memory-mapped I/O block for the Hack data bus: debounced inputs with sticky
// rising-edge flags, LED register, prescaled 16-bit timer with compare.
// Optional feature macro: HACK_IO_PWM_EN adds an 8-bit LED PWM at offset 6.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   address     CPU data address (addressM)
//   in          write data (outM)
//   load        write strobe (writeM)
//   out         read data, combinational, 0 when not selected
//   sel         address falls in the 8-word window at BASE
//   pmod        raw asynchronous inputs
//   led         LED drive
module hack_io_ctrl
  import hack_io_pkg::*;
#(
  parameter int unsigned     ADDR_W          = 16,
  parameter int unsigned     BASE            = 32'h6010,
  parameter int unsigned     N_IN            = 4,
  parameter int unsigned     N_OUT           = 5,
  parameter int unsigned     DEBOUNCE_CYCLES = 120000,
  parameter int unsigned     TICK_DIV        = 12000,
  parameter logic [N_IN-1:0] IN_INIT         = {N_IN{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       in,
  input  logic              load,
  output logic [15:0]       out,
  output logic              sel,
  input  logic [N_IN-1:0]   pmod,
  output logic [N_OUT-1:0]  led
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam int unsigned       PRE_W     = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);

  logic [2:0]        off;
  logic              wr;
  logic [N_IN-1:0]   in_state, in_rise;
  logic [N_IN-1:0]   in_edge_q, in_edge_d;
  logic [N_OUT-1:0]  led_q, led_d;
  logic [15:0]       timer_q, timer_d, timer_inc;
  logic [15:0]       cmp_q, cmp_d;
  logic              status_q, status_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              tick;
  logic [15:0]       pwm_rd;
  logic [15:0]       rd;

  assign sel = (address[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign off = address[2:0];
  assign wr  = load && sel;

  // Per-channel synchroniser and debounce
  for (genvar g = 0; g < int'(N_IN); g++) begin : g_in
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (IN_INIT[g])
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (pmod[g]),
      .state_o (in_state[g]),
      .rise_c_o(in_rise[g])
    );
  end

  assign tick      = (presc_q == PRE_LAST);
  assign timer_inc = timer_q + 16'd1;

  // Register next-state; set events are applied after W1C so they win
  always_comb begin
    in_edge_d = in_edge_q;
    led_d     = led_q;
    timer_d   = timer_q;
    cmp_d     = cmp_q;
    status_d  = status_q;
    presc_d   = tick ? '0 : presc_q + PRE_W'(1);

    if (wr && off == OFF_IN_EDGE) in_edge_d = in_edge_q & ~in[N_IN-1:0];
    in_edge_d = in_edge_d | in_rise;

    if (wr && off == OFF_LED)                status_d = status_q;
    if (wr && off == OFF_LED)                led_d    = in[N_OUT-1:0];
    if (wr && off == OFF_CMP)                cmp_d    = in;
    if (wr && off == OFF_STATUS && in[0])    status_d = 1'b0;

    // A TIMER write overrides the tick and never raises a match
    if (wr && off == OFF_TIMER) begin
      timer_d = in;
      presc_d = '0;
    end else if (tick) begin
      timer_d = timer_inc;
      if (timer_inc == cmp_q) status_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_edge_q <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      cmp_q     <= '0;
      status_q  <= 1'b0;
      presc_q   <= '0;
    end else begin
      in_edge_q <= in_edge_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      presc_q   <= presc_d;
    end
  end

`ifdef HACK_IO_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d, pwm_cnt_q;
  logic             pwm_on;

  always_comb begin
    pwm_d = pwm_q;
    if (wr && off == OFF_PWM) pwm_d = in[PWM_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q     <= 8'hFF;
      pwm_cnt_q <= '0;
    end else begin
      pwm_q     <= pwm_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  // 0xFF means fully on rather than 255/256
  assign pwm_on = (pwm_q == 8'hFF) || (pwm_cnt_q < pwm_q);
  assign led    = led_q & {N_OUT{pwm_on}};
  assign pwm_rd = 16'(pwm_q);
`else
  assign led    = led_q;
  assign pwm_rd = '0;
`endif

  // Read mux, zero-extended, gated by sel
  always_comb begin
    rd = '0;
    case (off)
      OFF_IN_STATE: rd = 16'(in_state);
      OFF_IN_EDGE:  rd = 16'(in_edge_q);
      OFF_LED:      rd = 16'(led_q);
      OFF_TIMER:    rd = timer_q;
      OFF_CMP:      rd = cmp_q;
      OFF_STATUS:   rd = 16'(status_q);
      OFF_PWM:      rd = pwm_rd;
      default:      rd = '0;
    endcase
    out = sel ? rd : '0;
  end

endmodule

// File: tb/tb_hack_io_ctrl.sv
// Bench for hack_io_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=3, BASE=0x6010.
// Directed scenarios followed by randomized bus/pmod traffic; every cycle the
// DUT outputs are compared against a cycle-counting reference model.
module tb_hack_io_ctrl;

  localparam int DB = 4;
  localparam int TD = 3;

  logic        clk;
  logic        rst;
  logic [15:0] addr, din, dout;
  logic        ld, dsel;
  logic [3:0]  pmod;
  logic [4:0]  led;

  int n_cmp = 0;
  int n_err = 0;

  hack_io_ctrl #(
    .ADDR_W(16), .BASE(32'h6010), .N_IN(4), .N_OUT(5),
    .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .IN_INIT(4'hF)
  ) dut (
    .clk(clk), .reset(rst), .address(addr), .in(din), .load(ld),
    .out(dout), .sel(dsel), .pmod(pmod), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [3:0]  m_d1, m_d2, m_state, m_edge;
  int          m_streak [4];
  logic [4:0]  m_led;
  logic [15:0] m_timer, m_cmp;
  logic        m_status;
  int          m_since;
  logic [7:0]  m_pwm, m_pwmcnt;

  task automatic model_reset();
    m_d1 = 4'hF; m_d2 = 4'hF; m_state = 4'hF; m_edge = 4'h0;
    for (int i = 0; i < 4; i++) m_streak[i] = 0;
    m_led = '0; m_timer = '0; m_cmp = '0; m_status = 1'b0; m_since = 0;
    m_pwm = 8'hFF; m_pwmcnt = 8'h00;
  endtask

  // Advance the model by one clock using the inputs presented to the DUT
  task automatic model_step();
    logic       w;
    logic [2:0] o;
    logic [3:0] rise, synced;
    logic       tk;
    if (rst) begin
      model_reset();
      return;
    end
    w = ld && ((addr >> 3) == (16'h6010 >> 3));
    o = addr[2:0];
    // synchronised value seen now is what pmod was two edges ago
    synced = m_d2;
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      if (synced[i] != m_state[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DB) begin
          m_state[i]  = synced[i];
          m_streak[i] = 0;
          rise[i]     = synced[i];
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = pmod;
    if (w && o == 3'd1) m_edge = m_edge & ~din[3:0];
    m_edge = m_edge | rise;
    if (w && o == 3'd2) m_led = din[4:0];
    if (w && o == 3'd5 && din[0]) m_status = 1'b0;
    tk = (m_since % TD) == TD - 1;
    if (w && o == 3'd3) begin
      m_timer = din;
      m_since = 0;
    end else begin
      if (tk) begin
        m_timer = m_timer + 16'd1;
        if (m_timer == m_cmp) m_status = 1'b1;
      end
      m_since++;
    end
    if (w && o == 3'd4) m_cmp = din;
    if (w && o == 3'd6) m_pwm = din[7:0];
    m_pwmcnt = m_pwmcnt + 8'd1;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if ((a >> 3) != (16'h6010 >> 3)) return 16'h0000;
    case (a[2:0])
      3'd0: return {12'h0, m_state};
      3'd1: return {12'h0, m_edge};
      3'd2: return {11'h0, m_led};
      3'd3: return m_timer;
      3'd4: return m_cmp;
      3'd5: return {15'h0, m_status};
`ifdef HACK_IO_PWM_EN
      3'd6: return {8'h0, m_pwm};
`endif
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [4:0] model_led();
`ifdef HACK_IO_PWM_EN
    return (m_pwm == 8'hFF || m_pwmcnt < m_pwm) ? m_led : 5'd0;
`else
    return m_led;
`endif
  endfunction

  task automatic check_outputs();
    check_eq("sel", 32'(dsel), 32'((addr >> 3) == (16'h6010 >> 3)));
    check_eq("out", 32'(dout), 32'(model_read(addr)));
    check_eq("led", 32'(led), 32'(model_led()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    addr = a; din = d; ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    addr = a; ld = 1'b0;
    #1;
    v = dout;
  endtask

  logic [15:0] v;
  int          hi_cnt;

  initial begin
    rst = 1'b1; ld = 1'b0; addr = 16'h6010; din = '0; pmod = 4'hF;
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;
    rd(16'h6010, v); check_eq("reset_in_state", 32'(v), 32'h000F);
    rd(16'h6013, v); check_eq("reset_timer", 32'(v), 32'h0000);

    // Debounce latency 2+4 and glitch rejection
    pmod = 4'hE;
    repeat (5) tick();
    rd(16'h6010, v); check_eq("deb_before", 32'(v), 32'h000F);
    tick();
    rd(16'h6010, v); check_eq("deb_exact", 32'(v), 32'h000E);
    pmod = 4'hF;
    repeat (6) tick();
    wr_reg(16'h6011, 16'h000F);
    pmod = 4'hE;
    repeat (3) tick();
    pmod = 4'hF;
    repeat (8) tick();
    rd(16'h6010, v); check_eq("glitch_state", 32'(v), 32'h000F);
    rd(16'h6011, v); check_eq("glitch_edge", 32'(v), 32'h0000);

    // Sticky edges; set wins over same-cycle W1C of another bit
    pmod = 4'hD;
    repeat (7) tick();
    pmod = 4'hF;
    repeat (6) tick();
    rd(16'h6011, v); check_eq("edge_bit1", 32'(v), 32'h0002);
    pmod = 4'hB;
    repeat (7) tick();
    pmod = 4'hF;
    repeat (5) tick();
    wr_reg(16'h6011, 16'h0002);
    rd(16'h6011, v); check_eq("edge_w1c_set", 32'(v), 32'h0004);
    wr_reg(16'h6011, 16'h0004);

    // Timer compare, wrap, and STATUS set-vs-clear priority
    wr_reg(16'h6013, 16'h0000);
    wr_reg(16'h6015, 16'h0001);
    wr_reg(16'h6014, 16'h0002);
    repeat (3) tick();
    rd(16'h6015, v); check_eq("match_before", 32'(v), 32'h0000);
    tick();
    rd(16'h6015, v); check_eq("match", 32'(v), 32'h0001);
    rd(16'h6013, v); check_eq("timer_at_cmp", 32'(v), 32'h0002);
    wr_reg(16'h6013, 16'hFFFF);
    repeat (2) tick();
    rd(16'h6013, v); check_eq("timer_ffff", 32'(v), 32'hFFFF);
    tick();
    rd(16'h6013, v); check_eq("timer_wrap", 32'(v), 32'h0000);
    wr_reg(16'h6015, 16'h0001);
    rd(16'h6015, v); check_eq("status_clr", 32'(v), 32'h0000);
    repeat (4) tick();
    wr_reg(16'h6015, 16'h0001);
    rd(16'h6015, v); check_eq("status_set_wins", 32'(v), 32'h0001);
    wr_reg(16'h6015, 16'h0001);
    wr_reg(16'h6013, 16'h0002);
    rd(16'h6015, v); check_eq("timer_wr_nomatch", 32'(v), 32'h0000);

    // Decode boundaries and LED width masking
    wr_reg(16'h6012, 16'h000A);
    wr_reg(16'h600F, 16'h1234);
    wr_reg(16'h6018, 16'h1234);
    addr = 16'h600F; #1;
    check_eq("sel_600f", 32'(dsel), 32'h0);
    check_eq("out_600f", 32'(dout), 32'h0);
    addr = 16'h6018; #1;
    check_eq("sel_6018", 32'(dsel), 32'h0);
    rd(16'h6012, v); check_eq("led_kept", 32'(v), 32'h000A);
    tick();
    rd(16'h6014, v); check_eq("cmp_kept", 32'(v), 32'h0002);
    wr_reg(16'h6012, 16'h7FFF);
    rd(16'h6012, v); check_eq("led_mask", 32'(v), 32'h001F);

`ifdef HACK_IO_PWM_EN
    wr_reg(16'h6016, 16'h0040);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led == 5'h1F) hi_cnt++;
    end
    check_eq("pwm_duty", 32'(hi_cnt), 32'd64);
    wr_reg(16'h6016, 16'h00FF);
`else
    wr_reg(16'h6016, 16'h00AB);
    rd(16'h6016, v); check_eq("pwm_absent", 32'(v), 32'h0000);
    check_eq("led_direct", 32'(led), 32'h001F);
`endif

    // Asynchronous reset mid-run, checked before the next clock edge
    pmod = 4'hE;
    repeat (7) tick();
    pmod = 4'hF;
    rst = 1'b1;
    model_reset();
    addr = 16'h6010; #1;
    check_eq("arst_in_state", 32'(dout), 32'h000F);
    addr = 16'h6012; #1;
    check_eq("arst_led_reg", 32'(dout), 32'h0000);
    check_eq("arst_led", 32'(led), 32'h0000);
    addr = 16'h6013; #1;
    check_eq("arst_timer", 32'(dout), 32'h0000);
    addr = 16'h6015; #1;
    check_eq("arst_status", 32'(dout), 32'h0000);
    tick();
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) pmod[b] = ~pmod[b];
      if ($urandom_range(0, 3) == 0) addr = 16'h6008 + 16'($urandom_range(0, 23));
      else                           addr = 16'h6010 + 16'($urandom_range(0, 7));
      din = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      ld  = ($urandom_range(0, 2) == 0);
      tick();
    end
    ld = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
